// File: rtl/mem_access_stage.sv
// MEM pipeline stage between the EX/MEM and MEM/WB registers.
// Decodes loads and stores and runs a req/gnt/rvalid data-memory transaction.
// Load data is lane-aligned and then sign- or zero-extended.
// Upstream is stalled until the access completes.
// Non-memory ops, and misaligned memory ops, pass through in a single cycle.
module mem_access_stage #(
   parameter logic [5:0] ID_LB  = 6'd23,
   parameter logic [5:0] ID_LH  = 6'd24,
   parameter logic [5:0] ID_LW  = 6'd25,
   parameter logic [5:0] ID_LBU = 6'd26,
   parameter logic [5:0] ID_LHU = 6'd27,
   parameter logic [5:0] ID_SB  = 6'd28,
   parameter logic [5:0] ID_SH  = 6'd29,
   parameter logic [5:0] ID_SW  = 6'd30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [5:0]  instr_id_in,
   input  logic [4:0]  rd_addr_in,
   input  logic        rd_valid_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] store_data_in,
   input  logic [31:0] alu_result_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        valid_out,
   output logic [4:0]  rd_addr_out,
   output logic        rd_valid_out,
   output logic [31:0] rd_data_out,
   output logic        misaligned_out,
   output logic [31:0] fault_addr_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   logic [1:0]  state_q, state_d;

   // Transaction context captured in IDLE and held until completion
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  offset_q, offset_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [4:0]  rdAddr_q, rdAddr_d;
   logic        rdValid_q, rdValid_d;

   // Registered results toward MEM/WB
   logic        valid_q, valid_d;
   logic [4:0]  rdAddrOut_q, rdAddrOut_d;
   logic        rdValidOut_q, rdValidOut_d;
   logic [31:0] rdData_q, rdData_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] faultAddr_q, faultAddr_d;

   // Decode results of the instruction currently in the EX/MEM slot
   logic        isLoad;
   logic        isStore;
   logic [1:0]  opSize;
   logic        opSext;
   logic        memOp;
   logic        addrMisaligned;
   logic        alignedMemOp;
   logic [31:0] laneWdata;
   logic [3:0]  laneBe;
   logic        complete;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadData;

   // Classify the incoming instr_id into load/store, access size and extension
   always_comb begin
      isLoad  = 1'b0;
      isStore = 1'b0;
      opSize  = SIZE_WORD;
      opSext  = 1'b0;
      case (instr_id_in)
         ID_LB: begin
            isLoad = 1'b1;
            opSize = SIZE_BYTE;
            opSext = 1'b1;
         end
         ID_LH: begin
            isLoad = 1'b1;
            opSize = SIZE_HALF;
            opSext = 1'b1;
         end
         ID_LW: begin
            isLoad = 1'b1;
            opSize = SIZE_WORD;
         end
         ID_LBU: begin
            isLoad = 1'b1;
            opSize = SIZE_BYTE;
         end
         ID_LHU: begin
            isLoad = 1'b1;
            opSize = SIZE_HALF;
         end
         ID_SB: begin
            isStore = 1'b1;
            opSize  = SIZE_BYTE;
         end
         ID_SH: begin
            isStore = 1'b1;
            opSize  = SIZE_HALF;
         end
         ID_SW: begin
            isStore = 1'b1;
            opSize  = SIZE_WORD;
         end
         default: begin
            isLoad  = 1'b0;
            isStore = 1'b0;
         end
      endcase
   end

   // Alignment check: halves need addr[0]=0, words need addr[1:0]=0, bytes always fit
   always_comb begin
      memOp          = isLoad | isStore;
      addrMisaligned = 1'b0;
      if (memOp) begin
         if (opSize == SIZE_HALF)
            addrMisaligned = mem_addr_in[0];
         else if (opSize == SIZE_WORD)
            addrMisaligned = (mem_addr_in[1:0] != 2'b00);
      end
      alignedMemOp = valid_in & memOp & ~addrMisaligned;
   end

   // Store data is replicated across every lane the access could hit; byte enables pick the lane
   always_comb begin
      laneWdata = store_data_in;
      laneBe    = 4'hF;
      if (isStore) begin
         case (opSize)
            SIZE_BYTE: begin
               laneWdata = {4{store_data_in[7:0]}};
               laneBe    = 4'b0001 << mem_addr_in[1:0];
            end
            SIZE_HALF: begin
               laneWdata = {2{store_data_in[15:0]}};
               laneBe    = 4'b0011 << mem_addr_in[1:0];
            end
            default: begin
               laneWdata = store_data_in;
               laneBe    = 4'hF;
            end
         endcase
      end
   end

   // A store finishes on its grant; a load finishes on rvalid, which is only honoured in WAIT
   always_comb begin
      complete = ((state_q == REQ) & dmem_gnt & we_q) |
                 ((state_q == WAIT) & dmem_rvalid);
   end

   // Pick the addressed byte/halfword out of the returned word and extend it
   always_comb begin
      case (offset_q)
         2'd0:    loadByte = dmem_rdata[7:0];
         2'd1:    loadByte = dmem_rdata[15:8];
         2'd2:    loadByte = dmem_rdata[23:16];
         default: loadByte = dmem_rdata[31:24];
      endcase
      loadHalf = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (size_q)
         SIZE_BYTE: loadData = {{24{sext_q & loadByte[7]}}, loadByte};
         SIZE_HALF: loadData = {{16{sext_q & loadHalf[15]}}, loadHalf};
         default:   loadData = dmem_rdata;
      endcase
   end

   // Upstream holds while an aligned memory op occupies the slot and has not completed.
   // A load thus occupies the slot for at least IDLE, REQ and WAIT; a store for IDLE and REQ.
   always_comb begin
      stall_out = alignedMemOp & ~complete;
   end

   // FSM and result sequencing; valid_out is a bubble on any cycle that does not finish an op
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      offset_d     = offset_q;
      size_d       = size_q;
      sext_d       = sext_q;
      rdAddr_d     = rdAddr_q;
      rdValid_d    = rdValid_q;
      valid_d      = 1'b0;
      rdAddrOut_d  = rdAddrOut_q;
      rdValidOut_d = 1'b0;
      rdData_d     = rdData_q;
      misaligned_d = 1'b0;
      faultAddr_d  = faultAddr_q;
      case (state_q)
         IDLE: begin
            if (alignedMemOp) begin
               state_d   = REQ;
               we_d      = isStore;
               addr_d    = {mem_addr_in[31:2], 2'b00};
               wdata_d   = laneWdata;
               be_d      = laneBe;
               offset_d  = mem_addr_in[1:0];
               size_d    = opSize;
               sext_d    = opSext;
               rdAddr_d  = rd_addr_in;
               rdValid_d = rd_valid_in;
            end else if (valid_in && memOp) begin
               valid_d      = 1'b1;
               rdAddrOut_d  = rd_addr_in;
               rdValidOut_d = 1'b0;
               rdData_d     = 32'd0;
               misaligned_d = 1'b1;
               faultAddr_d  = mem_addr_in;
            end else if (valid_in) begin
               valid_d      = 1'b1;
               rdAddrOut_d  = rd_addr_in;
               rdValidOut_d = rd_valid_in;
               rdData_d     = alu_result_in;
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               if (we_q) begin
                  state_d      = IDLE;
                  valid_d      = 1'b1;
                  rdAddrOut_d  = rdAddr_q;
                  rdValidOut_d = 1'b0;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               state_d      = IDLE;
               valid_d      = 1'b1;
               rdAddrOut_d  = rdAddr_q;
               rdValidOut_d = rdValid_q;
               rdData_d     = loadData;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         be_q         <= 4'd0;
         offset_q     <= 2'd0;
         size_q       <= SIZE_BYTE;
         sext_q       <= 1'b0;
         rdAddr_q     <= 5'd0;
         rdValid_q    <= 1'b0;
         valid_q      <= 1'b0;
         rdAddrOut_q  <= 5'd0;
         rdValidOut_q <= 1'b0;
         rdData_q     <= 32'd0;
         misaligned_q <= 1'b0;
         faultAddr_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         offset_q     <= offset_d;
         size_q       <= size_d;
         sext_q       <= sext_d;
         rdAddr_q     <= rdAddr_d;
         rdValid_q    <= rdValid_d;
         valid_q      <= valid_d;
         rdAddrOut_q  <= rdAddrOut_d;
         rdValidOut_q <= rdValidOut_d;
         rdData_q     <= rdData_d;
         misaligned_q <= misaligned_d;
         faultAddr_q  <= faultAddr_d;
      end
   end

   // Memory port is driven from the captured context so it stays stable until granted
   always_comb begin
      dmem_req   = (state_q == REQ);
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
      dmem_be    = be_q;
   end

   // Result outputs come straight from their registers
   always_comb begin
      valid_out      = valid_q;
      rd_addr_out    = rdAddrOut_q;
      rd_valid_out   = rdValidOut_q;
      rd_data_out    = rdData_q;
      misaligned_out = misaligned_q;
      fault_addr_out = faultAddr_q;
   end

endmodule
